// File: rtl/barcode_entry_sequencer_pkg.sv
// Shared key codes, FSM state encoding and key classification for the
// barcode entry sequencer.
package barcode_entry_sequencer_pkg;

  localparam logic [3:0] KEY_CLEAR   = 4'hA;
  localparam logic [3:0] KEY_ENTER   = 4'hB;
  // Value the shift register shows in every position after a clear.
  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENTRY  = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/barcode_entry_sequencer_if.sv
// Keypad, shift-register and lookup signals of the barcode entry sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface barcode_entry_sequencer_if;
  logic       KEY_VALID;
  logic [3:0] KEY_CODE;
  logic       SR_ENABLE;
  logic [3:0] SR_DIGIT;
  logic       SR_CLEAR_N;
  logic       LOOKUP_REQ;
  logic       LOOKUP_ACK;
  logic       LOOKUP_FOUND;
  logic       ITEM_VALID;
  logic       ERROR;
  logic [2:0] DIGIT_COUNT;

  modport master (
    output KEY_VALID, KEY_CODE, LOOKUP_ACK, LOOKUP_FOUND,
    input  SR_ENABLE, SR_DIGIT, SR_CLEAR_N, LOOKUP_REQ, ITEM_VALID, ERROR, DIGIT_COUNT
  );

  modport slave (
    input  KEY_VALID, KEY_CODE, LOOKUP_ACK, LOOKUP_FOUND,
    output SR_ENABLE, SR_DIGIT, SR_CLEAR_N, LOOKUP_REQ, ITEM_VALID, ERROR, DIGIT_COUNT
  );
endinterface

// File: rtl/barcode_entry_sequencer_entry_timer.sv
// Saturating down-counter with reload; expire pulses for one cycle on the
// cycle after the count reaches zero.
module barcode_entry_sequencer_entry_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expire
);

  logic [WIDTH-1:0] count_r;
  logic             expire_r;

  // Load wins over counting; a load also cancels any pending expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r  <= '0;
      expire_r <= 1'b0;
    end else if (load) begin
      count_r  <= load_value;
      expire_r <= 1'b0;
    end else if (enable && (count_r != '0)) begin
      count_r  <= count_r - WIDTH'(1);
      expire_r <= (count_r == WIDTH'(1));
    end else begin
      expire_r <= 1'b0;
    end
  end

  assign expire = expire_r;

endmodule

// File: rtl/barcode_entry_sequencer.sv
// Keypad-to-shift-register sequencer: shifts digits, checks the digit count,
// runs the item lookup handshake and reports ITEM_VALID or ERROR.
module barcode_entry_sequencer
  import barcode_entry_sequencer_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int IDLE_TIMEOUT = 50_000_000,
  parameter int ERR_HOLD     = 25_000_000
) (
  input logic                        CLK,
  input logic                        RESET,
  barcode_entry_sequencer_if.slave   bus
);

  localparam int TMAX = (IDLE_TIMEOUT > ERR_HOLD) ? IDLE_TIMEOUT : ERR_HOLD;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  // The timer expires one cycle after reaching zero, so reload with N-1.
  localparam logic [TW-1:0] IDLE_RELOAD = TW'(IDLE_TIMEOUT - 1);
  localparam logic [TW-1:0] ERR_RELOAD  = TW'(ERR_HOLD - 1);
  localparam logic [2:0]    FULL_COUNT  = 3'(NUM_DIGITS);

  state_t        state_r;
  logic          sr_enable_r;
  logic [3:0]    sr_digit_r;
  logic          sr_clear_n_r;
  logic          lookup_req_r;
  logic          item_valid_r;
  logic          error_r;
  logic [2:0]    digit_count_r;

  logic          tmr_load_s;
  logic [TW-1:0] tmr_value_s;
  logic          tmr_enable_s;
  logic          tmr_expire_s;

  // Timer reload: held loaded outside ENTRY/ERROR, so entering either state starts a fresh count.
  always_comb begin
    tmr_load_s  = 1'b0;
    tmr_value_s = IDLE_RELOAD;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        tmr_load_s = 1'b1;
      end
      ST_ENTRY: begin
        if (bus.KEY_VALID) begin
          tmr_load_s = 1'b1;
          if ((bus.KEY_CODE == KEY_ENTER) && (digit_count_r != FULL_COUNT)) begin
            tmr_value_s = ERR_RELOAD;
          end else begin
            tmr_value_s = IDLE_RELOAD;
          end
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      ST_LOOKUP: begin
        tmr_load_s  = 1'b1;
        tmr_value_s = ERR_RELOAD;
      end
      ST_ERROR: begin
        tmr_load_s = 1'b0;
      end
      default: begin
        tmr_load_s = 1'b1;
      end
    endcase
  end

  assign tmr_enable_s = (state_r == ST_ENTRY) || (state_r == ST_ERROR);

  barcode_entry_sequencer_entry_timer #(.WIDTH(TW)) u_timer (
    .clk        (CLK),
    .rst        (RESET),
    .load       (tmr_load_s),
    .load_value (tmr_value_s),
    .enable     (tmr_enable_s),
    .expire     (tmr_expire_s)
  );

  // Main FSM with registered outputs; strobes default low, clear defaults inactive.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r       <= ST_IDLE;
      sr_enable_r   <= 1'b0;
      sr_digit_r    <= 4'd0;
      sr_clear_n_r  <= 1'b0;
      lookup_req_r  <= 1'b0;
      item_valid_r  <= 1'b0;
      error_r       <= 1'b0;
      digit_count_r <= 3'd0;
    end else begin
      sr_enable_r  <= 1'b0;
      item_valid_r <= 1'b0;
      sr_clear_n_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (bus.KEY_VALID) begin
            if (is_digit(bus.KEY_CODE)) begin
              sr_enable_r   <= 1'b1;
              sr_digit_r    <= bus.KEY_CODE;
              digit_count_r <= 3'd1;
              state_r       <= ST_ENTRY;
            end else if (bus.KEY_CODE == KEY_CLEAR) begin
              sr_clear_n_r  <= 1'b0;
              digit_count_r <= 3'd0;
            end
          end
        end
        ST_ENTRY: begin
          if (bus.KEY_VALID) begin
            if (is_digit(bus.KEY_CODE)) begin
              // A digit beyond the barcode length is dropped without a shift.
              if (digit_count_r < FULL_COUNT) begin
                sr_enable_r   <= 1'b1;
                sr_digit_r    <= bus.KEY_CODE;
                digit_count_r <= digit_count_r + 3'd1;
              end
            end else if (bus.KEY_CODE == KEY_CLEAR) begin
              sr_clear_n_r  <= 1'b0;
              digit_count_r <= 3'd0;
              state_r       <= ST_IDLE;
            end else if (bus.KEY_CODE == KEY_ENTER) begin
              if (digit_count_r == FULL_COUNT) begin
                lookup_req_r <= 1'b1;
                state_r      <= ST_LOOKUP;
              end else begin
                error_r <= 1'b1;
                state_r <= ST_ERROR;
              end
            end
          end else if (tmr_expire_s) begin
            sr_clear_n_r  <= 1'b0;
            digit_count_r <= 3'd0;
            state_r       <= ST_IDLE;
          end
        end
        ST_LOOKUP: begin
          if (bus.LOOKUP_ACK) begin
            lookup_req_r <= 1'b0;
            if (bus.LOOKUP_FOUND) begin
              item_valid_r <= 1'b1;
              state_r      <= ST_DONE;
            end else begin
              error_r <= 1'b1;
              state_r <= ST_ERROR;
            end
          end
        end
        ST_DONE: begin
          if (bus.KEY_VALID) begin
            sr_clear_n_r  <= 1'b0;
            digit_count_r <= 3'd0;
            state_r       <= ST_IDLE;
          end
        end
        ST_ERROR: begin
          if ((bus.KEY_VALID && (bus.KEY_CODE == KEY_CLEAR)) || tmr_expire_s) begin
            sr_clear_n_r  <= 1'b0;
            digit_count_r <= 3'd0;
            error_r       <= 1'b0;
            state_r       <= ST_IDLE;
          end
        end
        default: begin
          sr_clear_n_r  <= 1'b0;
          digit_count_r <= 3'd0;
          lookup_req_r  <= 1'b0;
          error_r       <= 1'b0;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.SR_ENABLE   = sr_enable_r;
  assign bus.SR_DIGIT    = sr_digit_r;
  assign bus.SR_CLEAR_N  = sr_clear_n_r;
  assign bus.LOOKUP_REQ  = lookup_req_r;
  assign bus.ITEM_VALID  = item_valid_r;
  assign bus.ERROR       = error_r;
  assign bus.DIGIT_COUNT = digit_count_r;

endmodule
